// File: rtl/kayrv32_mem_pkg.sv
// Shared encodings for the KayRV32 load/store data memory:
// RV32I funct3 size codes and response fault codes.
package kayrv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISAL   = 2'b01;
  localparam logic [1:0] FLT_RANGE   = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

endpackage

// File: rtl/ram_sp_be.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered,
// enable-gated read port so the read word holds while the consumer stalls.
module ram_sp_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ls.sv
// Byte-addressed RV32I load/store data memory for the MEM stage with
// fault detection and a one-deep valid/ready response register.
module data_mem_ls
  import kayrv32_mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [2:0]  i_ReqFunct3,
  input  logic [31:0] i_ReqAddr,
  input  logic [31:0] i_ReqData,
  output logic        o_RspValid,
  input  logic        i_RspReady,
  output logic [31:0] o_RspData,
  output logic [31:0] o_RspAddr,
  output logic [1:0]  o_RspFault
);

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    fmt_load = {{24{b[7]}}, b};
      F3_BU:   fmt_load = {24'h0, b};
      F3_H:    fmt_load = {{16{h[15]}}, h};
      F3_HU:   fmt_load = {16'h0, h};
      default: fmt_load = w;
    endcase
  endfunction

  logic          accept;
  logic          illegal_p0, misal_p0, range_p0;
  logic [1:0]    fault_p0;
  logic [1:0]    off_p0;
  logic [3:0]    lane_p0;
  logic [31:0]   wdata_p0;
  logic [3:0]    we_p0;
  logic          ren_p0;

  logic          vld_p1;
  logic          load_p1;
  logic [31:0]   addr_p1;
  logic [1:0]    fault_p1;
  logic [2:0]    f3_p1;
  logic [1:0]    off_p1;
  logic [31:0]   word_p1;

  assign o_ReqReady = !vld_p1 || i_RspReady;
  assign accept     = i_ReqValid && o_ReqReady;
  assign off_p0     = i_ReqAddr[1:0];

  // Stage p0: decode, fault priority, lane enables and store-data replication
  always_comb begin
    if (i_ReqWrite)
      illegal_p0 = !(i_ReqFunct3 inside {F3_B, F3_H, F3_W});
    else
      illegal_p0 = !(i_ReqFunct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal_p0 = ((i_ReqFunct3[1:0] == 2'b01) && off_p0[0]) ||
               ((i_ReqFunct3[1:0] == 2'b10) && (off_p0 != 2'b00));
    range_p0 = |(i_ReqAddr >> (AW + 2));
    if (illegal_p0)    fault_p0 = FLT_ILLEGAL;
    else if (misal_p0) fault_p0 = FLT_MISAL;
    else if (range_p0) fault_p0 = FLT_RANGE;
    else               fault_p0 = FLT_NONE;

    case (i_ReqFunct3[1:0])
      2'b00: begin
        lane_p0  = 4'b0001 << off_p0;
        wdata_p0 = {4{i_ReqData[7:0]}};
      end
      2'b01: begin
        lane_p0  = 4'b0011 << {off_p0[1], 1'b0};
        wdata_p0 = {2{i_ReqData[15:0]}};
      end
      default: begin
        lane_p0  = 4'b1111;
        wdata_p0 = i_ReqData;
      end
    endcase

    // Reset in the accept cycle suppresses the write entirely.
    we_p0  = (accept && i_ReqWrite && (fault_p0 == FLT_NONE) && !i_Rst) ? lane_p0 : 4'b0000;
    ren_p0 = accept && !i_ReqWrite && !i_Rst;
  end

  ram_sp_be #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (i_Clk),
    .we    (we_p0),
    .en    (ren_p0),
    .addr  (i_ReqAddr[AW+1:2]),
    .wdata (wdata_p0),
    .rdata (word_p1)
  );

  // Stage p1: response register with handshake
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vld_p1   <= 1'b0;
      load_p1  <= 1'b0;
      addr_p1  <= 32'h0;
      fault_p1 <= FLT_NONE;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      load_p1  <= !i_ReqWrite && (fault_p0 == FLT_NONE);
      addr_p1  <= i_ReqAddr;
      fault_p1 <= fault_p0;
    end else if (i_RspReady) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (accept) begin
      f3_p1  <= i_ReqFunct3;
      off_p1 <= off_p0;
    end
  end

  assign o_RspValid = vld_p1;
  assign o_RspAddr  = addr_p1;
  assign o_RspFault = fault_p1;
  assign o_RspData  = load_p1 ? fmt_load(word_p1, f3_p1, off_p1) : 32'h0;

endmodule

// File: tb/tb_data_mem_ls.sv
// Directed bench for data_mem_ls: sizes, extension, faults, backpressure,
// back-to-back throughput and reset during a pending response.
module tb_data_mem_ls;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_ls #(.DEPTH(1024)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_ReqValid  (req_valid),
    .o_ReqReady  (req_ready),
    .i_ReqWrite  (req_write),
    .i_ReqFunct3 (req_f3),
    .i_ReqAddr   (req_addr),
    .i_ReqData   (req_data),
    .o_RspValid  (rsp_valid),
    .i_RspReady  (rsp_ready),
    .o_RspData   (rsp_data),
    .o_RspAddr   (rsp_addr),
    .o_RspFault  (rsp_fault)
  );

  // Drives one request for one cycle and samples the response 1ns after the edge.
  task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, output logic [66:0] obs);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    obs = {rsp_valid, rsp_fault, rsp_addr, rsp_data};
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_f3 = 3'b000;
    req_addr = 32'h0; req_data = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({rsp_valid, rsp_fault, rsp_addr, rsp_data} !== 67'h0) begin
      n_err++;
      $display("FAIL reset_state got v=%b f=%b a=%h d=%h want all zero", rsp_valid, rsp_fault, rsp_addr, rsp_data);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_word();
    logic [66:0] o;
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h10, 32'h0}) begin
      n_err++; $display("FAIL sw_10 got %h want %h", o, {1'b1, 2'b00, 32'h10, 32'h0});
    end
    req(1'b0, 3'b010, 32'h10, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL lw_10 got %h want %h", o, {1'b1, 2'b00, 32'h10, 32'hDEADBEEF});
    end
  endtask

  task automatic test_byte();
    logic [66:0] o;
    req(1'b1, 3'b010, 32'h20, 32'h0, o);
    req(1'b1, 3'b000, 32'h21, 32'h7F, o);
    req(1'b0, 3'b010, 32'h20, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h20, 32'h00007F00}) begin
      n_err++; $display("FAIL sb_lw_20 got %h want %h", o, {1'b1, 2'b00, 32'h20, 32'h00007F00});
    end
    req(1'b0, 3'b000, 32'h21, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h21, 32'h0000007F}) begin
      n_err++; $display("FAIL lb_21 got %h want %h", o, {1'b1, 2'b00, 32'h21, 32'h0000007F});
    end
    req(1'b1, 3'b000, 32'h22, 32'hAAAAAA80, o);
    req(1'b0, 3'b000, 32'h22, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h22, 32'hFFFFFF80}) begin
      n_err++; $display("FAIL lb_22 got %h want %h", o, {1'b1, 2'b00, 32'h22, 32'hFFFFFF80});
    end
    req(1'b0, 3'b100, 32'h22, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h22, 32'h00000080}) begin
      n_err++; $display("FAIL lbu_22 got %h want %h", o, {1'b1, 2'b00, 32'h22, 32'h00000080});
    end
  endtask

  task automatic test_half();
    logic [66:0] o;
    req(1'b1, 3'b010, 32'h30, 32'h0, o);
    req(1'b1, 3'b001, 32'h32, 32'h1234BEEF, o);
    req(1'b0, 3'b001, 32'h32, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h32, 32'hFFFFBEEF}) begin
      n_err++; $display("FAIL lh_32 got %h want %h", o, {1'b1, 2'b00, 32'h32, 32'hFFFFBEEF});
    end
    req(1'b0, 3'b101, 32'h32, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h32, 32'h0000BEEF}) begin
      n_err++; $display("FAIL lhu_32 got %h want %h", o, {1'b1, 2'b00, 32'h32, 32'h0000BEEF});
    end
    req(1'b0, 3'b001, 32'h33, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b01, 32'h33, 32'h0}) begin
      n_err++; $display("FAIL lh_33_misal got %h want %h", o, {1'b1, 2'b01, 32'h33, 32'h0});
    end
    req(1'b1, 3'b010, 32'h31, 32'h12345678, o);
    n_vec++;
    if (o !== {1'b1, 2'b01, 32'h31, 32'h0}) begin
      n_err++; $display("FAIL sw_31_misal got %h want %h", o, {1'b1, 2'b01, 32'h31, 32'h0});
    end
    req(1'b0, 3'b010, 32'h30, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h30, 32'hBEEF0000}) begin
      n_err++; $display("FAIL lw_30_unchanged got %h want %h", o, {1'b1, 2'b00, 32'h30, 32'hBEEF0000});
    end
  endtask

  task automatic test_faults();
    logic [66:0] o;
    req(1'b0, 3'b010, 32'h1000, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b10, 32'h1000, 32'h0}) begin
      n_err++; $display("FAIL lw_range got %h want %h", o, {1'b1, 2'b10, 32'h1000, 32'h0});
    end
    req(1'b0, 3'b011, 32'h10, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b11, 32'h10, 32'h0}) begin
      n_err++; $display("FAIL ld_f3_011 got %h want %h", o, {1'b1, 2'b11, 32'h10, 32'h0});
    end
    req(1'b0, 3'b011, 32'h1001, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b11, 32'h1001, 32'h0}) begin
      n_err++; $display("FAIL prio_illegal got %h want %h", o, {1'b1, 2'b11, 32'h1001, 32'h0});
    end
    req(1'b0, 3'b010, 32'h1002, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b01, 32'h1002, 32'h0}) begin
      n_err++; $display("FAIL prio_misal got %h want %h", o, {1'b1, 2'b01, 32'h1002, 32'h0});
    end
    req(1'b1, 3'b100, 32'h10, 32'h55555555, o);
    n_vec++;
    if (o !== {1'b1, 2'b11, 32'h10, 32'h0}) begin
      n_err++; $display("FAIL sb_f3_100 got %h want %h", o, {1'b1, 2'b11, 32'h10, 32'h0});
    end
    req(1'b0, 3'b010, 32'h10, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL illegal_no_write got %h want %h", o, {1'b1, 2'b00, 32'h10, 32'hDEADBEEF});
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_f3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({req_ready, rsp_valid, rsp_fault, rsp_addr, rsp_data} !== {1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF}) begin
        n_err++;
        $display("FAIL stall_%0d got rdy=%b v=%b f=%b a=%h d=%h want rdy=0 v=1 f=00 a=00000010 d=deadbeef",
                 i, req_ready, rsp_valid, rsp_fault, rsp_addr, rsp_data);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_vec++;
    if ({rsp_valid, rsp_fault, rsp_addr, rsp_data} !== {1'b1, 2'b00, 32'h20, 32'h00807F00}) begin
      n_err++;
      $display("FAIL stall_release got v=%b f=%b a=%h d=%h want v=1 f=00 a=00000020 d=00807f00",
               rsp_valid, rsp_fault, rsp_addr, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    addrs = '{32'h10, 32'h20, 32'h30, 32'h32};
    exp   = '{32'hDEADBEEF, 32'h00807F00, 32'hBEEF0000, 32'hFFFFBEEF};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i];
      req_f3   = (i == 3) ? 3'b001 : 3'b010;
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, addrs[i], exp[i]}) begin
        n_err++;
        $display("FAIL b2b_%0d got v=%b a=%h d=%h want v=1 a=%h d=%h",
                 i, rsp_valid, rsp_addr, rsp_data, addrs[i], exp[i]);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [66:0] o;
    req(1'b0, 3'b010, 32'h10, 32'h0, o);
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_f3 = 3'b010; req_addr = 32'h10; req_data = 32'h11111111;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_valid got %b want 0", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({rsp_valid, rsp_data} !== 33'h0) begin
      n_err++; $display("FAIL rst_mid_after got v=%b d=%h want v=0 d=0", rsp_valid, rsp_data);
    end
    req(1'b0, 3'b010, 32'h10, 32'h0, o);
    n_vec++;
    if (o !== {1'b1, 2'b00, 32'h10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL rst_mid_no_write got %h want %h", o, {1'b1, 2'b00, 32'h10, 32'hDEADBEEF});
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ls.md
# data_mem_ls

Parametrised load/store data memory for the KayRV32 MEM stage. It replaces the plain word-addressed data memory with a byte-addressed, byte-lane-enabled array. It handles RV32I load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) with sign/zero extension and detects misaligned, out-of-range and illegal accesses. A valid/ready request and response handshake gives one-cycle latency, full throughput and response backpressure.

## Interface
- DEPTH, 1024, number of 32-bit words; must be a power of two ≥ 2
- AW, $clog2(DEPTH), word-index width (derived, not overridden)
- i_Clk  in  1  clock; all state updates on rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_ReqValid  in  1  request present
- o_ReqReady  out  1  request accepted this cycle when high together with i_ReqValid
- i_ReqWrite  in  1  1 = store, 0 = load
- i_ReqFunct3  in  3  RV32I funct3 size/sign code
- i_ReqAddr  in  32  byte address
- i_ReqData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- o_RspValid  out  1  response present
- i_RspReady  in  1  consumer takes response this cycle
- o_RspData  out  32  formatted load data; 0 for stores and faults
- o_RspAddr  out  32  byte address of the request that produced this response
- o_RspFault  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3

## Operation
- Word index = i_ReqAddr[AW+1:2]. Byte offset = i_ReqAddr[1:0].
- Accept = i_ReqValid && o_ReqReady. o_ReqReady = !o_RspValid || i_RspReady, which is combinational from i_RspReady.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3 values: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Fault priority is illegal > misaligned > out of range.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠00.
  - Out of range: i_ReqAddr[31:AW+2] ≠ 0.
- Store on accept with no fault:
  - Byte lanes written: SB writes lane = offset. SH writes lanes {offset+1, offset}. SW writes all four lanes.
  - Store data is replicated onto the selected lanes.
  - Unselected lanes are unchanged.
- Faulting stores write nothing. Every store still produces one response with o_RspData=0.
- Load on accept: the word is read and registered with the offset and funct3.
  - The response extracts the byte or half at the offset.
  - LB/LH sign-extend to 32 bits. LBU/LHU zero-extend. LW passes the word through.
- Faulting loads respond with data 0 and the fault code.
- Memory contents are not reset. Simulation initial contents are X.

## Timing
- Reset values: o_RspValid=0, o_RspData=0, o_RspAddr=0, o_RspFault=00. o_ReqReady=1 once reset is released.
- If reset is asserted mid-operation, a pending response is dropped. A store accepted in the same cycle that reset is asserted is not written.
- Latency: a request accepted at edge N produces its response valid after edge N.
- Throughput: one request per cycle while i_RspReady=1.
- Backpressure: while o_RspValid && !i_RspReady, o_ReqReady=0 and all o_Rsp* signals hold stable.
- When o_RspValid && i_RspReady and a new request is accepted in the same cycle, the response is replaced at the next edge with no bubble.
- Read-after-write: a store accepted at edge N is visible to a load accepted at edge N+1 or later.
- Same-cycle load and store cannot occur because there is a single request port.

## Structure
- Package kayrv32_mem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - fault codes FLT_NONE, FLT_MISAL, FLT_RANGE, FLT_ILLEGAL
- Sub-module ram_sp_be: single-port DEPTH×32 RAM with a 4-bit byte-write enable and registered read.
  - Read is enabled only on load accept, so the output holds under stall.
- data_mem_ls contains:
  - the decode and fault logic
  - lane-enable and store-data replication
  - the response register stage with the handshake
  - load formatting on the registered offset and funct3

## Test plan
- Reset, then SW 0xDEADBEEF @0x10 followed by LW @0x10 → 0xDEADBEEF with fault 00, one cycle after each accept.
- SB 0x7F @0x21 onto 0x00000000 @0x20, then LW @0x20 → 0x00007F00. LB @0x21 → 0x0000007F. SB 0x80 @0x22 then LB @0x22 → 0xFFFFFF80 and LBU @0x22 → 0x00000080.
- SH 0xBEEF @0x32 then LH @0x32 → 0xFFFFBEEF and LHU → 0x0000BEEF. LH @0x33 → fault 01 with data 0. SW @0x31 → fault 01, and a following LW @0x30 shows the word unchanged.
- With DEPTH=1024, LW @0x1000 → fault 10. A load with funct3=011 → fault 11. SB with funct3=100 → fault 11 and no write.
- Backpressure: i_RspReady=0 for 3 cycles after a load → o_ReqReady=0 and the response stays stable. Back-to-back loads with i_RspReady=1 → one response per cycle, in order.
- Assert i_Rst while a response is pending and a store is presented → after release o_RspValid=0, and a readback shows the store was not written.
